fc_layer_engine: RTL and testbench

Parameterised fully-connected layer engine. It is the responder side of the TPU layer-sequencing handshake: the controller raises ena and releases reset, and the engine then runs one complete layer.
Per output neuron it streams 128-lane weight rows from the shared block ROM and drives the shared combinational multiply-adder. It accumulates over input chunks, requantises the sum, writes the lane into its output vector and finally asserts done.
One instance serves each layer (FC1/FC2/FC3) by parameter choice.

---
 rtl/tpu_pkg.sv | 34 +++
 rtl/fc_requant.sv | 39 +++
 rtl/fc_layer_engine.sv | 184 ++++++++++++++++++
 tb/tb_fc_layer_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions used by the layer engines.
//   - default lane width and lane count
//   - ROM row address width
//   - layer-engine FSM state encoding
//   - constant helpers for chunk counts and bit widths
package tpu_pkg;

    localparam int unsigned BIT_DEF   = 8;
    localparam int unsigned LANES_DEF = 128;
    localparam int unsigned ROM_AW    = 11;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StMac,
        StStore,
        StDone
    } fc_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Smallest r with 2**r >= v; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantiser shared by all fully-connected layers.
// Arithmetic right shift of the accumulator, optional ReLU, then saturation to a
// signed BIT-wide activation.
//   acc : signed accumulator, ACC_W bits (in)
//   r   : signed requantised activation, BIT bits (out)
module fc_requant
    import tpu_pkg::*;
#(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned BIT   = BIT_DEF,
    parameter int unsigned SHIFT = 7,
    parameter int unsigned RELU  = 1
) (
    input  logic [ACC_W-1:0] acc,
    output logic [BIT-1:0]   r
);

    localparam logic signed [ACC_W-1:0] MaxVal = ACC_W'((1 << (BIT - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MinVal = ~MaxVal;

    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] sh;

    assign acc_s = acc;
    assign sh    = acc_s >>> SHIFT;

    always_comb begin
        if (RELU != 0 && sh[ACC_W-1]) begin
            r = '0;
        end else if (sh > MaxVal) begin
            r = MaxVal[BIT-1:0];
        end else if (sh < MinVal) begin
            r = MinVal[BIT-1:0];
        end else begin
            r = sh[BIT-1:0];
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine. Once enabled it computes every output neuron by
// streaming LANES-wide weight rows from the block ROM, accumulating the shared
// multiply-adder result over input chunks, requantising and storing one lane per
// neuron, then raising done.
//   clk                 : clock
//   iRst_n              : asynchronous active-low reset
//   ena                 : enable; low freezes all state
//   data_from_rom       : weight row, valid one cycle after addr_to_rom
//   data_from_ram       : layer input vector, stable for the whole run
//   data_from_MultAdder : combinational signed dot product of the operands
//   done                : layer complete (held until reset)
//   addr_to_rom         : registered ROM row address
//   opr1_to_MultAdder   : weight operand (zero outside MAC)
//   opr2_to_MultAdder   : input operand (zero outside MAC)
//   data_to_ram         : output activations, lane j = neuron j
module fc_layer_engine
    import tpu_pkg::*;
#(
    parameter int unsigned BIT       = BIT_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned N_IN      = 1024,
    parameter int unsigned IN_BIT    = 1,
    parameter int unsigned IN_SIGNED = 0,
    parameter int unsigned N_OUT     = 128,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned SHIFT     = 7,
    parameter int unsigned RELU      = 1
) (
    input  logic                      clk,
    input  logic                      iRst_n,
    input  logic                      ena,
    input  logic [LANES*BIT-1:0]      data_from_rom,
    input  logic [N_IN*IN_BIT-1:0]    data_from_ram,
    input  logic [2*BIT-2:0]          data_from_MultAdder,
    output logic                      done,
    output logic [ROM_AW-1:0]         addr_to_rom,
    output logic [LANES*BIT-1:0]      opr1_to_MultAdder,
    output logic [LANES*BIT-1:0]      opr2_to_MultAdder,
    output logic [LANES*BIT-1:0]      data_to_ram
);

    localparam int unsigned N_CHUNK = ceil_div(N_IN, LANES);
    localparam int unsigned MA_W    = 2 * BIT - 1;
    localparam int unsigned ACC_W   = MA_W + clog2(N_CHUNK) + 1;
    localparam int unsigned C_W     = (N_CHUNK > 1) ? clog2(N_CHUNK) : 1;
    localparam int unsigned J_W     = (N_OUT > 1) ? clog2(N_OUT) : 1;
    localparam int unsigned N_SLOT  = 1 << C_W;

    fc_state_e               state_q, state_d;
    logic [J_W-1:0]          j_q, j_d;
    logic [C_W-1:0]          c_q, c_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    done_q, done_d;
    logic [ROM_AW-1:0]       addr_q, addr_d;
    logic [LANES*BIT-1:0]    ram_q, ram_d;

    logic signed [ACC_W-1:0] ma_ext;
    logic [BIT-1:0]          req_r;

    // Input vector regrouped into LANES-wide chunks of extended elements. Slots past
    // N_IN (tail of the last chunk and unused power-of-two slots) read as zero.
    logic [N_SLOT-1:0][LANES*BIT-1:0] chunk_vec;

    for (genvar ch = 0; ch < N_SLOT; ch++) begin : g_chunk
        for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
            if (ch * LANES + ln < N_IN) begin : g_in
                logic [IN_BIT-1:0] raw;
                assign raw = data_from_ram[(ch*LANES+ln)*IN_BIT +: IN_BIT];
                if (IN_SIGNED != 0) begin : g_sext
                    logic signed [IN_BIT-1:0] raw_s;
                    logic signed [BIT-1:0]    ext;
                    assign raw_s = raw;
                    assign ext   = raw_s;
                    assign chunk_vec[ch][ln*BIT +: BIT] = ext;
                end else begin : g_zext
                    assign chunk_vec[ch][ln*BIT +: BIT] = BIT'(raw);
                end
            end else begin : g_pad
                assign chunk_vec[ch][ln*BIT +: BIT] = '0;
            end
        end
    end

    assign ma_ext = {{(ACC_W - MA_W){data_from_MultAdder[MA_W-1]}}, data_from_MultAdder};

    fc_requant #(
        .ACC_W (ACC_W),
        .BIT   (BIT),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_requant (
        .acc (acc_q),
        .r   (req_r)
    );

    always_comb begin
        state_d           = state_q;
        j_d               = j_q;
        c_d               = c_q;
        acc_d             = acc_q;
        done_d            = done_q;
        addr_d            = addr_q;
        ram_d             = ram_q;
        opr1_to_MultAdder = '0;
        opr2_to_MultAdder = '0;

        unique case (state_q)
            StIdle: begin
                if (ena) begin
                    addr_d  = ROM_AW'(BASE_ADDR);
                    acc_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (ena) state_d = StMac;
            end
            StMac: begin
                // Operands stay driven while frozen; the ROM address is unchanged so
                // the row on data_from_rom remains valid.
                opr1_to_MultAdder = data_from_rom;
                opr2_to_MultAdder = chunk_vec[c_q];
                if (ena) begin
                    acc_d = acc_q + ma_ext;
                    if (c_q != C_W'(N_CHUNK - 1)) begin
                        c_d     = c_q + C_W'(1);
                        addr_d  = addr_q + ROM_AW'(1);
                        state_d = StFetch;
                    end else begin
                        state_d = StStore;
                    end
                end
            end
            StStore: begin
                if (ena) begin
                    for (int unsigned i = 0; i < N_OUT; i++) begin
                        if (j_q == J_W'(i)) ram_d[i*BIT +: BIT] = req_r;
                    end
                    acc_d = '0;
                    c_d   = '0;
                    if (j_q == J_W'(N_OUT - 1)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        j_d     = j_q + J_W'(1);
                        addr_d  = ROM_AW'(BASE_ADDR + (int'(j_q) + 1) * N_CHUNK);
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                // Terminal; only reset leaves this state.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StIdle;
            j_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            ram_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            ram_q   <= ram_d;
        end
    end

    assign done        = done_q;
    assign addr_to_rom = addr_q;
    assign data_to_ram = ram_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
module tb_fc_layer_engine;

    typedef struct {
        logic [1023:0] vec;
        int            lat;
        int            top;
        int            start;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ena_a, ena_b, ena_c;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight ROM images and extended input values, one set per DUT
    logic [1023:0] rom_m [3][1024];
    int            inval [3][1024];

    logic [1023:0] rom_q_a, rom_q_b, rom_q_c;
    logic [127:0]  ram_a;
    logic [1023:0] ram_b;
    logic [2047:0] ram_c;
    logic [14:0]   ma_a, ma_b, ma_c;
    logic          done_a, done_b, done_c;
    logic [10:0]   addr_a, addr_b, addr_c;
    logic [1023:0] o1_a, o1_b, o1_c, o2_a, o2_b, o2_c, out_a, out_b, out_c;

    logic          done_v [3];
    logic [10:0]   addr_v [3];
    logic [1023:0] o1_v [3];
    logic [1023:0] o2_v [3];
    logic [1023:0] out_v [3];

    assign done_v[0] = done_a;  assign done_v[1] = done_b;  assign done_v[2] = done_c;
    assign addr_v[0] = addr_a;  assign addr_v[1] = addr_b;  assign addr_v[2] = addr_c;
    assign o1_v[0]   = o1_a;    assign o1_v[1]   = o1_b;    assign o1_v[2]   = o1_c;
    assign o2_v[0]   = o2_a;    assign o2_v[1]   = o2_b;    assign o2_v[2]   = o2_c;
    assign out_v[0]  = out_a;   assign out_v[1]  = out_b;   assign out_v[2]  = out_c;

    // ROM with one cycle of read latency
    always @(posedge clk) begin
        rom_q_a <= rom_m[0][addr_a[9:0]];
        rom_q_b <= rom_m[1][addr_b[9:0]];
        rom_q_c <= rom_m[2][addr_c[9:0]];
    end

    // Behavioural 128-lane signed multiply-adder, 15-bit result
    function automatic logic [14:0] dot(input logic [1023:0] a, input logic [1023:0] b);
        int  s;
        byte x, y;
        s = 0;
        for (int i = 0; i < 128; i++) begin
            x = a[i*8 +: 8];
            y = b[i*8 +: 8];
            s += int'(x) * int'(y);
        end
        return s[14:0];
    endfunction

    assign ma_a = dot(o1_a, o2_a);
    assign ma_b = dot(o1_b, o2_b);
    assign ma_c = dot(o1_c, o2_c);

    fc_layer_engine #(
        .BIT(8), .LANES(128), .N_IN(128), .IN_BIT(1), .IN_SIGNED(0),
        .N_OUT(2), .BASE_ADDR(0), .SHIFT(0), .RELU(0)
    ) dut_a (
        .clk(clk), .iRst_n(rst_n), .ena(ena_a), .data_from_rom(rom_q_a),
        .data_from_ram(ram_a), .data_from_MultAdder(ma_a), .done(done_a),
        .addr_to_rom(addr_a), .opr1_to_MultAdder(o1_a), .opr2_to_MultAdder(o2_a),
        .data_to_ram(out_a)
    );

    fc_layer_engine dut_b (
        .clk(clk), .iRst_n(rst_n), .ena(ena_b), .data_from_rom(rom_q_b),
        .data_from_ram(ram_b), .data_from_MultAdder(ma_b), .done(done_b),
        .addr_to_rom(addr_b), .opr1_to_MultAdder(o1_b), .opr2_to_MultAdder(o2_b),
        .data_to_ram(out_b)
    );

    fc_layer_engine #(
        .BIT(8), .LANES(128), .N_IN(256), .IN_BIT(8), .IN_SIGNED(1),
        .N_OUT(4), .BASE_ADDR(5), .SHIFT(2), .RELU(0)
    ) dut_c (
        .clk(clk), .iRst_n(rst_n), .ena(ena_c), .data_from_rom(rom_q_c),
        .data_from_ram(ram_c), .data_from_MultAdder(ma_c), .done(done_c),
        .addr_to_rom(addr_c), .opr1_to_MultAdder(o1_c), .opr2_to_MultAdder(o2_c),
        .data_to_ram(out_c)
    );

    // Reference model: neuron n = sum_k W[n][k] * x[k], weight W[n][k] stored in row
    // base + n*ceil(n_in/128) + k/128, lane k%128; then shift, ReLU, saturate.
    function automatic logic [1023:0] model(input int d, input int n_in, input int n_out,
                                            input int base, input int shift, input bit relu);
        logic [1023:0] v;
        logic [7:0]    wb;
        byte           w;
        longint        s, r;
        int            nch;
        v   = '0;
        nch = (n_in + 127) / 128;
        for (int n = 0; n < n_out; n++) begin
            s = 0;
            for (int k = 0; k < n_in; k++) begin
                wb = rom_m[d][base + n * nch + k / 128][(k % 128) * 8 +: 8];
                w  = wb;
                s += longint'(w) * longint'(inval[d][k]);
            end
            r = s >>> shift;
            if (relu && r < 0) r = 0;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            v[n*8 +: 8] = r[7:0];
        end
        return v;
    endfunction

    exp_t q_a[$], q_b[$], q_c[$];

    function automatic int qsize(input int d);
        case (d)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic exp_t pop(input int d);
        case (d)
            0:       return q_a.pop_front();
            1:       return q_b.pop_front();
            default: return q_c.pop_front();
        endcase
    endfunction

    function automatic string nm(input int d);
        case (d)
            0:       return "A";
            1:       return "B";
            default: return "C";
        endcase
    endfunction

    task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got(low128) %0h required(low128) %0h", name, got[127:0], req[127:0]);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        chk({nm(d), "_", tag, "_done"}, 1024'(done_v[d]), '0);
        chk({nm(d), "_", tag, "_addr"}, 1024'(addr_v[d]), '0);
        chk({nm(d), "_", tag, "_opr1"}, o1_v[d], '0);
        chk({nm(d), "_", tag, "_opr2"}, o2_v[d], '0);
        chk({nm(d), "_", tag, "_ram"}, out_v[d], '0);
    endtask

    task automatic check_run(input int d, input exp_t e, input logic [1023:0] vec, input int mx);
        int bad;
        checks++;
        if (vec !== e.vec) begin
            errors++;
            bad = 0;
            for (int i = 127; i >= 0; i--) if (vec[i*8 +: 8] !== e.vec[i*8 +: 8]) bad = i;
            $display("FAIL %s_data lane %0d got %0d required %0d", nm(d), bad,
                     $signed(vec[bad*8 +: 8]), $signed(e.vec[bad*8 +: 8]));
        end
        chk({nm(d), "_latency"}, 1024'(cyc - e.start), 1024'(e.lat));
        chk({nm(d), "_max_addr"}, 1024'(mx), 1024'(e.top));
    endtask

    // Monitor: pops an expectation on each rising done and compares
    initial begin
        logic prev [3];
        int   maxad [3];
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            prev[d]  = 1'b0;
            maxad[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) maxad[d] = 0;
                else if (int'(addr_v[d]) > maxad[d]) maxad[d] = int'(addr_v[d]);
                if (rst_n && done_v[d] && !prev[d]) begin
                    if (qsize(d) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s_spurious_done got done=1 required no run", nm(d));
                    end else begin
                        e = pop(d);
                        check_run(d, e, out_v[d], maxad[d]);
                    end
                end
                prev[d] = done_v[d];
            end
        end
    end

    task automatic start_run(input int d, input int n_in, input int n_out, input int base,
                             input int shift, input bit relu, input int extra,
                             output int k);
        exp_t e;
        int   nch;
        @(negedge clk);
        nch     = (n_in + 127) / 128;
        e.vec   = model(d, n_in, n_out, base, shift, relu);
        e.lat   = n_out * (2 * nch + 1) + 1 + extra;
        e.top   = base + n_out * nch - 1;
        e.start = cyc;
        k       = cyc;
        case (d)
            0:       begin q_a.push_back(e); ena_a = 1'b1; end
            1:       begin q_b.push_back(e); ena_b = 1'b1; end
            default: begin q_c.push_back(e); ena_c = 1'b1; end
        endcase
    endtask

    task automatic wait_drain(input int d, input int budget);
        for (int i = 0; i < budget && qsize(d) != 0; i++) @(negedge clk);
        checks++;
        if (qsize(d) != 0) begin
            errors++;
            $display("FAIL %s_timeout got no done within %0d cycles required done", nm(d), budget);
            while (qsize(d) != 0) void'(pop(d));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ena_a = 1'b0;
        ena_b = 1'b0;
        ena_c = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_w(input int d, input int row, input int lane, input int val);
        logic [31:0] v;
        v = val;
        rom_m[d][row][lane*8 +: 8] = v[7:0];
    endtask

    // FC1 data with positively biased weights so activations are mostly nonzero
    task automatic fill_b_random();
        for (int r = 0; r < 1024; r++)
            for (int l = 0; l < 128; l++) set_w(1, r, l, int'($urandom_range(0, 7)) - 2);
        for (int k = 0; k < 1024; k++) begin
            inval[1][k] = int'($urandom_range(0, 1));
            ram_b[k]    = inval[1][k][0];
        end
    endtask

    int k0;

    initial begin
        rst_n = 1'b0;
        ena_a = 1'b0;
        ena_b = 1'b0;
        ena_c = 1'b0;
        ram_a = '0;
        ram_b = '0;
        ram_c = '0;
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 1024; r++) begin
                rom_m[d][r] = '0;
                inval[d][r] = 0;
            end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int d = 0; d < 3; d++) check_zero(d, "idle");

        // A: row0 all +1, row1 all -1, input all ones -> 127 and -128
        for (int l = 0; l < 128; l++) begin
            set_w(0, 0, l, 1);
            set_w(0, 1, l, -1);
            inval[0][l] = 1;
        end
        ram_a = '1;
        start_run(0, 128, 2, 0, 0, 1'b0, 0, k0);
        wait_drain(0, 100);

        // B: random FC1 with three directed neurons (1>>>7=0, 1016>>>7=7, -500 -> ReLU 0)
        fill_b_random();
        for (int r = 0; r < 24; r++) rom_m[1][r] = '0;
        set_w(1, 0, 0, 1);
        for (int l = 0; l < 8; l++) set_w(1, 8, l, 127);
        for (int l = 0; l < 4; l++) set_w(1, 16, l, -125);
        for (int k = 0; k < 8; k++) begin
            inval[1][k] = 1;
            ram_b[k]    = 1'b1;
        end
        start_run(1, 1024, 128, 0, 7, 1'b1, 0, k0);
        wait_drain(1, 3000);

        // B: ena dropped for 5 cycles during the third MAC
        do_reset();
        fill_b_random();
        start_run(1, 1024, 128, 0, 7, 1'b1, 5, k0);
        for (int i = 0; i < 20 && cyc != k0 + 6; i++) @(negedge clk);
        ena_b = 1'b0;
        repeat (5) @(negedge clk);
        ena_b = 1'b1;
        wait_drain(1, 3000);

        // B: reset during STORE of neuron 40, then a clean rerun of the same data
        do_reset();
        fill_b_random();
        k0    = cyc;
        ena_b = 1'b1;
        for (int i = 0; i < 800 && cyc != k0 + 697; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        ena_b = 1'b0;
        #1;
        check_zero(1, "abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(1, 1024, 128, 0, 7, 1'b1, 0, k0);
        wait_drain(1, 3000);

        // C: signed 8-bit inputs, BASE_ADDR=5, SHIFT=2, no ReLU: -125, +127, -128, random
        for (int r = 0; r < 32; r++)
            for (int l = 0; l < 128; l++) set_w(2, r, l, int'($urandom_range(0, 6)) - 3);
        for (int r = 5; r <= 10; r++) rom_m[2][r] = '0;
        for (int l = 0; l < 125; l++) begin
            set_w(2, 5, l, -4);
            set_w(2, 7, l, 8);
            set_w(2, 9, l, -8);
        end
        for (int k = 0; k < 256; k++) begin
            logic [31:0] v;
            inval[2][k] = (k < 128) ? 1 : int'($urandom_range(0, 8)) - 4;
            v = inval[2][k];
            ram_c[k*8 +: 8] = v[7:0];
        end
        start_run(2, 256, 4, 5, 2, 1'b0, 0, k0);
        wait_drain(2, 200);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1, "watchdog");
    end

endmodule
